// File: rtl/lamp_pkg.sv
// Shared lamp-bus codes, phase encodings and monitor state enum.
// Used by the lamp sequence monitor and the cyclic lamp controller.
package lamp_pkg;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_GREEN  = 3'b010;
    localparam logic [2:0] LIGHT_YELLOW = 3'b001;

    typedef enum logic [1:0] {
        PH_RED     = 2'd0,
        PH_GREEN   = 2'd1,
        PH_YELLOW  = 2'd2,
        PH_INVALID = 2'd3
    } phase_t;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_RED,
        ST_GREEN,
        ST_YELLOW
    } mon_state_t;

    function automatic phase_t decode_light(input logic [2:0] code);
        case (code)
            LIGHT_RED:    return PH_RED;
            LIGHT_GREEN:  return PH_GREEN;
            LIGHT_YELLOW: return PH_YELLOW;
            default:      return PH_INVALID;
        endcase
    endfunction

    function automatic phase_t state_phase(input mon_state_t st);
        case (st)
            ST_RED:    return PH_RED;
            ST_GREEN:  return PH_GREEN;
            ST_YELLOW: return PH_YELLOW;
            default:   return PH_INVALID;
        endcase
    endfunction

    // Successor state in the legal R->G->Y->R cycle.
    function automatic mon_state_t next_state_in_cycle(input mon_state_t st);
        case (st)
            ST_RED:    return ST_GREEN;
            ST_GREEN:  return ST_YELLOW;
            ST_YELLOW: return ST_RED;
            default:   return ST_HUNT;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear together with inc loads 1.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= inc ? W'(1) : '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/lamp_sequence_monitor.sv
// Receive-side checker for the one-hot lamp bus: locks onto R->G->Y->R,
// counts completed cycles and flags code, order and dwell-time violations.
//
// state     | meaning
// ST_HUNT   | no legal sequence tracked; waiting for Red
// ST_RED    | tracking Red phase
// ST_GREEN  | tracking Green phase
// ST_YELLOW | tracking Yellow phase
module lamp_sequence_monitor
    import lamp_pkg::*;
#(
    parameter int MIN_DWELL = 1,
    parameter int MAX_DWELL = 1,
    parameter int DW        = 8,
    parameter int CW        = 8,
    parameter int EW        = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [0:2]    light,
    output logic [1:0]    phase,
    output logic          locked,
    output logic          code_err,
    output logic          seq_err,
    output logic          dwell_err,
    output logic [CW-1:0] cycle_count,
    output logic [EW-1:0] err_count
);

    mon_state_t    state, state_nx;
    phase_t        phase_q, sample_ph, cur_ph, exp_ph;
    logic          code_nx, seq_nx, dwell_nx;
    logic          dwell_clear, dwell_inc, cyc_inc, err_inc;
    logic [DW-1:0] dwell;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_HUNT;
            phase_q   <= PH_INVALID;
            code_err  <= 1'b0;
            seq_err   <= 1'b0;
            dwell_err <= 1'b0;
        end else begin
            state     <= state_nx;
            phase_q   <= sample_ph;
            code_err  <= code_nx;
            seq_err   <= seq_nx;
            dwell_err <= dwell_nx;
        end
    end

    always_comb begin
        sample_ph   = decode_light(light);
        cur_ph      = state_phase(state);
        exp_ph      = state_phase(next_state_in_cycle(state));
        state_nx    = state;
        code_nx     = 1'b0;
        seq_nx      = 1'b0;
        dwell_nx    = 1'b0;
        dwell_clear = 1'b0;
        dwell_inc   = 1'b0;
        cyc_inc     = 1'b0;

        if (state == ST_HUNT) begin
            if (sample_ph == PH_RED) begin
                state_nx    = ST_RED;
                dwell_clear = 1'b1;
                dwell_inc   = 1'b1;
            end else if (sample_ph == PH_INVALID) begin
                code_nx = 1'b1;
            end
        end else if (sample_ph == PH_INVALID) begin
            code_nx     = 1'b1;
            state_nx    = ST_HUNT;
            dwell_clear = 1'b1;
        end else if (sample_ph == cur_ph) begin
            dwell_inc = 1'b1;
            // dwell only ever passes MAX_DWELL once per phase, so this fires once
            dwell_nx  = (dwell == DW'(MAX_DWELL));
        end else if (sample_ph == exp_ph) begin
            state_nx    = next_state_in_cycle(state);
            dwell_clear = 1'b1;
            dwell_inc   = 1'b1;
            dwell_nx    = (dwell < DW'(MIN_DWELL));
            cyc_inc     = (state == ST_YELLOW);
        end else begin
            seq_nx      = 1'b1;
            dwell_clear = 1'b1;
            // an unexpected Red is still a valid cycle start, so resync at once
            if (sample_ph == PH_RED) begin
                state_nx  = ST_RED;
                dwell_inc = 1'b1;
            end else begin
                state_nx  = ST_HUNT;
            end
        end

        err_inc = code_nx | seq_nx | dwell_nx;
    end

    sat_counter #(.W(DW)) u_dwell (
        .clock (clock),
        .reset (reset),
        .clear (dwell_clear),
        .inc   (dwell_inc),
        .count (dwell)
    );

    sat_counter #(.W(CW)) u_cycle (
        .clock (clock),
        .reset (reset),
        .clear (1'b0),
        .inc   (cyc_inc),
        .count (cycle_count)
    );

    sat_counter #(.W(EW)) u_err (
        .clock (clock),
        .reset (reset),
        .clear (1'b0),
        .inc   (err_inc),
        .count (err_count)
    );

    assign phase  = phase_q;
    assign locked = (state != ST_HUNT);

endmodule

// File: tb/tb_lamp_sequence_monitor.sv
// Directed bench for lamp_sequence_monitor: default, MIN/MAX dwell and narrow
// cycle-counter configurations, each on its own instance.
module tb_lamp_sequence_monitor;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] G = 3'b010;
    localparam logic [2:0] Y = 3'b001;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int tests    = 0;
    int failures = 0;

    logic       reset_a, reset_b, reset_c;
    logic [0:2] light_a, light_b, light_c;

    logic [1:0] phase_a, phase_b, phase_c;
    logic       locked_a, locked_b, locked_c;
    logic       code_a, code_b, code_c;
    logic       seq_a, seq_b, seq_c;
    logic       dwell_a, dwell_b, dwell_c;
    logic [7:0] cyc_a, cyc_b;
    logic [1:0] cyc_c;
    logic [7:0] err_a, err_b, err_c;

    lamp_sequence_monitor u_a (
        .clock(clock), .reset(reset_a), .light(light_a), .phase(phase_a),
        .locked(locked_a), .code_err(code_a), .seq_err(seq_a), .dwell_err(dwell_a),
        .cycle_count(cyc_a), .err_count(err_a)
    );

    lamp_sequence_monitor #(.MIN_DWELL(2), .MAX_DWELL(4)) u_b (
        .clock(clock), .reset(reset_b), .light(light_b), .phase(phase_b),
        .locked(locked_b), .code_err(code_b), .seq_err(seq_b), .dwell_err(dwell_b),
        .cycle_count(cyc_b), .err_count(err_b)
    );

    lamp_sequence_monitor #(.CW(2)) u_c (
        .clock(clock), .reset(reset_c), .light(light_c), .phase(phase_c),
        .locked(locked_c), .code_err(code_c), .seq_err(seq_c), .dwell_err(dwell_c),
        .cycle_count(cyc_c), .err_count(err_c)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [2:0] seq1 [7];
        logic [1:0] ph1  [7];
        logic [2:0] seqb [8];
        logic       dweb [8];

        seq1 = '{R, G, Y, R, G, Y, R};
        ph1  = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};

        reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
        light_a = 3'b000; light_b = 3'b000; light_c = 3'b000;
        tick();
        tick();

        check("rst_phase",  phase_a,  2'd3);
        check("rst_locked", locked_a, 1'b0);
        check("rst_cycle",  cyc_a,    8'd0);
        check("rst_err",    err_a,    8'd0);
        check("rst_pulses", {code_a, seq_a, dwell_a}, 3'b000);

        // 1: legal sequence
        reset_a = 1'b0;
        for (int i = 0; i < 7; i++) begin
            light_a = seq1[i];
            tick();
            check($sformatf("t1_phase_%0d", i),  phase_a,  ph1[i]);
            check($sformatf("t1_locked_%0d", i), locked_a, 1'b1);
            check($sformatf("t1_pulses_%0d", i), {code_a, seq_a, dwell_a}, 3'b000);
        end
        check("t1_cycle", cyc_a, 8'd2);
        check("t1_err",   err_a, 8'd0);

        // 2: illegal code while in GREEN
        light_a = G; tick();
        check("t2_green_locked", locked_a, 1'b1);
        light_a = 3'b110; tick();
        check("t2_code_err", code_a,   1'b1);
        check("t2_seq_err",  seq_a,    1'b0);
        check("t2_phase",    phase_a,  2'd3);
        check("t2_locked",   locked_a, 1'b0);
        check("t2_err",      err_a,    8'd1);
        light_a = G; tick();
        check("t2_code_drop", code_a,   1'b0);
        check("t2_hunt_g",    locked_a, 1'b0);
        check("t2_err_hold",  err_a,    8'd1);

        // 3: out-of-order and Red resync
        light_a = R; tick();
        check("t3_lock_r", locked_a, 1'b1);
        light_a = Y; tick();
        check("t3_seq_err", seq_a,    1'b1);
        check("t3_locked",  locked_a, 1'b0);
        check("t3_phase",   phase_a,  2'd2);
        check("t3_err",     err_a,    8'd2);
        light_a = G; tick();
        check("t3_seq_drop", seq_a,    1'b0);
        check("t3_hunt_g",   locked_a, 1'b0);
        light_a = R; tick();
        check("t3_relock", locked_a, 1'b1);
        light_a = G; tick();
        light_a = R; tick();
        check("t3_resync_seq",    seq_a,    1'b1);
        check("t3_resync_locked", locked_a, 1'b1);
        check("t3_resync_err",    err_a,    8'd3);
        check("t3_cycle_hold",    cyc_a,    8'd2);
        light_a = 3'b111; tick();
        check("t3_all_ones_code", code_a, 1'b1);
        check("t3_all_ones_err",  err_a,  8'd4);

        // 4: MAX_DWELL=1
        reset_a = 1'b1; tick();
        check("t4_rst_err", err_a, 8'd0);
        reset_a = 1'b0;
        light_a = R; tick();
        check("t4_r1_dwell", dwell_a, 1'b0);
        light_a = R; tick();
        check("t4_r2_dwell", dwell_a, 1'b1);
        light_a = R; tick();
        check("t4_r3_dwell",  dwell_a,  1'b0);
        check("t4_r3_locked", locked_a, 1'b1);
        light_a = G; tick();
        check("t4_g_dwell",  dwell_a,  1'b0);
        check("t4_g_phase",  phase_a,  2'd1);
        check("t4_g_locked", locked_a, 1'b1);
        check("t4_err",      err_a,    8'd1);
        light_a = 3'b000; tick();
        check("t4_zero_code",  code_a,  1'b1);
        check("t4_zero_dwell", dwell_a, 1'b0);
        check("t4_zero_err",   err_a,   8'd2);

        // 5: MIN_DWELL=2, MAX_DWELL=4
        seqb = '{R, R, G, R, R, G, Y, Y};
        dweb = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        reset_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            light_b = seqb[i];
            tick();
            check($sformatf("t5_dwell_%0d", i), dwell_b, dweb[i]);
            if (i == 3) begin
                check("t5_resync_seq",    seq_b,    1'b1);
                check("t5_resync_locked", locked_b, 1'b1);
            end
        end
        check("t5_err", err_b, 8'd2);
        light_b = Y; tick();
        check("t5_y3", dwell_b, 1'b0);
        light_b = Y; tick();
        check("t5_y4", dwell_b, 1'b0);
        light_b = Y; tick();
        check("t5_y5_max", dwell_b, 1'b1);
        light_b = Y; tick();
        check("t5_y6", dwell_b, 1'b0);
        check("t5_err_final", err_b, 8'd3);

        // 6: CW=2 saturation, then reset mid-GREEN
        reset_c = 1'b0;
        light_c = R; tick();
        check("t6_cycle_0", cyc_c, 2'd0);
        for (int k = 1; k <= 5; k++) begin
            light_c = G; tick();
            light_c = Y; tick();
            light_c = R; tick();
            check($sformatf("t6_cycle_%0d", k), cyc_c, (k > 3) ? 2'd3 : 2'(k));
        end
        light_c = G; tick();
        check("t6_green_locked", locked_c, 1'b1);
        check("t6_err",          err_c,    8'd0);
        reset_c = 1'b1; tick();
        check("t6_rst_cycle",  cyc_c,    2'd0);
        check("t6_rst_err",    err_c,    8'd0);
        check("t6_rst_locked", locked_c, 1'b0);
        check("t6_rst_phase",  phase_c,  2'd3);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
